// File: rtl/cpu_phase_sequencer_if.sv
// rtl/cpu_phase_sequencer_if.sv - board-side and datapath-side signal bundle for the phase sequencer
interface cpu_phase_sequencer_if #(
    parameter int PHASE_W = 3,
    parameter int COUNT_W = 32
);
    logic [1:0]         mode;
    logic               step_btn;
    logic [31:0]        bp_addr;
    logic [31:0]        pc;
    logic [PHASE_W-1:0] phase;
    logic               cpu_clk;
    logic               pc_en;
    logic               reg_en;
    logic               instr_done;
    logic               halted;
    logic [COUNT_W-1:0] instr_count;

    // Board / datapath side: drives controls and the current PC, observes sequencing.
    modport master (
        output mode, step_btn, bp_addr, pc,
        input  phase, cpu_clk, pc_en, reg_en, instr_done, halted, instr_count
    );

    // Sequencer side.
    modport slave (
        input  mode, step_btn, bp_addr, pc,
        output phase, cpu_clk, pc_en, reg_en, instr_done, halted, instr_count
    );
endinterface

// File: rtl/cpu_phase_sequencer.sv
// rtl/cpu_phase_sequencer.sv - multi-phase instruction sequencer with run/step/halt/breakpoint modes
module cpu_phase_sequencer #(
    parameter int PHASES          = 8,
    parameter int PHASE_W         = 3,
    parameter int CLK_BIT         = 1,
    parameter int PC_PHASE        = 1,
    parameter int WB_PHASE        = 6,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int COUNT_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst_a,
    cpu_phase_sequencer_if.slave bus
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(PHASES - 1);
    localparam logic [PHASE_W-1:0] PC_PH   = PHASE_W'(PC_PHASE);
    localparam logic [PHASE_W-1:0] WB_PH   = PHASE_W'(WB_PHASE);

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_HALT = 2'b10;
    localparam logic [1:0] MODE_BRK  = 2'b11;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_EXEC = 2'd1,
        S_BRK  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PHASE_W-1:0] phase_q;
    logic [COUNT_W-1:0] count_q;
    logic               bp_skip_q;

    logic               btn_meta;
    logic               btn_sync;
    logic               btn_acc;
    logic [DB_W-1:0]    db_cnt;
    logic               press;
    logic               instr_end;

    // Two-flop synchroniser, then accept a new level only after it has been stable long enough.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_acc  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_meta <= bus.step_btn;
            btn_sync <= btn_meta;
            if (btn_sync == btn_acc) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_acc <= btn_sync;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Press fires in the cycle the accepted level is about to rise; releases are ignored.
    assign press     = btn_sync & ~btn_acc & (db_cnt == DB_LAST);
    assign instr_end = (state_q == S_EXEC) && (phase_q == LAST_PH);

    // State, phase, retired count and the one-shot breakpoint bypass.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q   <= S_WAIT;
            phase_q   <= '0;
            count_q   <= '0;
            bp_skip_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= (state_q == S_EXEC) ? phase_q + PHASE_W'(1) : '0;
            if (instr_end) begin
                count_q <= count_q + COUNT_W'(1);
            end
            // An instruction released from BRK must not stop again on its own boundary.
            if (state_q == S_BRK && state_d == S_EXEC) begin
                bp_skip_q <= 1'b1;
            end else if (instr_end) begin
                bp_skip_q <= 1'b0;
            end
        end
    end

    // Next state: modes only take effect at instruction boundaries while executing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (bus.mode == MODE_RUN || bus.mode == MODE_BRK) begin
                    state_d = S_EXEC;
                end else if (bus.mode == MODE_STEP && press) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (phase_q == LAST_PH) begin
                    case (bus.mode)
                        MODE_RUN:  state_d = S_EXEC;
                        MODE_STEP: state_d = S_WAIT;
                        MODE_HALT: state_d = S_WAIT;
                        default:   state_d = (bus.pc == bus.bp_addr && !bp_skip_q) ? S_BRK : S_EXEC;
                    endcase
                end
            end
            S_BRK: begin
                if (bus.mode != MODE_BRK) begin
                    state_d = S_WAIT;
                end else if (press) begin
                    state_d = S_EXEC;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    // Datapath strobes decode from registered state and phase; all low while stopped.
    always_comb begin
        bus.phase       = phase_q;
        bus.instr_count = count_q;
        bus.halted      = (state_q != S_EXEC);
        bus.pc_en       = (state_q == S_EXEC) && (phase_q == PC_PH);
        bus.reg_en      = (state_q == S_EXEC) && (phase_q == WB_PH);
        bus.cpu_clk     = (state_q == S_EXEC) && phase_q[CLK_BIT];
        bus.instr_done  = instr_end;
    end
endmodule
